da_dot_engine: RTL and testbench

Parametrised distributed-arithmetic (DA) dot-product engine for the DCT datapath. It computes y = Σ x_k·c_k over TAPS signed samples against compile-time coefficients in Q(COEF_W-COEF_FRAC).COEF_FRAC, bit-serially, one input bit per cycle. The partial-sum LUT is generated at elaboration from the coefficient parameter, so a single block serves any DCT row or filter row. It sits between the sample buffer and the RLE stage, with valid/ready handshakes on both sides.

---
 rtl/da_pkg.sv | 46 ++++
 rtl/da_dot_engine_if.sv | 30 +++
 rtl/da_lut.sv | 38 +++
 rtl/da_dot_engine.sv | 127 ++++++++++++
 tb/tb_da_dot_engine.sv | 276 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/da_pkg.sv
// Shared definitions for the distributed-arithmetic dot-product engine.
// Contents:
//   clog2 / lut_w / out_w   width helpers used by the engine, LUT and bus
//   da_state_t              engine FSM states
//   DCT_C1..DCT_C7          DCT cosine constants, Q2.14
//   DCT_ROW*_COEFS          packed 4-tap coefficient sets (coef k at [k*16 +: 16])
package da_pkg;

    function automatic int clog2(input int value);
        int result;
        result = 0;
        while ((1 << result) < value) result++;
        return result;
    endfunction

    function automatic int lut_w(input int coef_w, input int taps);
        return coef_w + clog2(taps);
    endfunction

    function automatic int out_w(input int in_w, input int coef_w, input int taps);
        return in_w + coef_w + clog2(taps);
    endfunction

    function automatic logic [15:0] neg_q14(input logic [15:0] c);
        return ~c + 16'd1;
    endfunction

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_DONE
    } da_state_t;

    localparam logic [15:0] DCT_C1 = 16'h3EC5;
    localparam logic [15:0] DCT_C2 = 16'h3B21;
    localparam logic [15:0] DCT_C3 = 16'h3537;
    localparam logic [15:0] DCT_C4 = 16'h2D41;
    localparam logic [15:0] DCT_C5 = 16'h238E;
    localparam logic [15:0] DCT_C6 = 16'h187E;
    localparam logic [15:0] DCT_C7 = 16'h0C7C;

    localparam logic [63:0] DCT_ROW0_COEFS = {DCT_C4, DCT_C4, DCT_C4, DCT_C4};
    localparam logic [63:0] DCT_ROW2_COEFS = {neg_q14(DCT_C2), neg_q14(DCT_C6), DCT_C6, DCT_C2};
    localparam logic [63:0] DCT_ROW7_COEFS = {DCT_C7, neg_q14(DCT_C5), DCT_C3, neg_q14(DCT_C1)};

endpackage

// File: rtl/da_dot_engine_if.sv
// Handshake bundle between the sample buffer, the DA engine and the RLE stage.
//   in_valid/in_ready/in_data     sample vector, x_k at [k*IN_W +: IN_W]
//   out_valid/out_ready/out_data  signed dot-product result
//   busy                          engine is computing or holding a result
// slave modport is the engine side; master is the surrounding datapath.
interface da_dot_engine_if #(
    parameter int TAPS   = 4,
    parameter int IN_W   = 16,
    parameter int COEF_W = 16
);
    localparam int OUT_W = da_pkg::out_w(IN_W, COEF_W, TAPS);

    logic                    in_valid;
    logic                    in_ready;
    logic [TAPS*IN_W-1:0]    in_data;
    logic                    out_valid;
    logic                    out_ready;
    logic signed [OUT_W-1:0] out_data;
    logic                    busy;

    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data, busy
    );

    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data, busy
    );
endinterface

// File: rtl/da_lut.sv
// Constant partial-sum table for distributed arithmetic.
//   addr   bit k selects coefficient k
//   entry  sum of the selected sign-extended coefficients (LUT_W bits)
// The table is built at elaboration from COEFS; entry[0] is zero.
module da_lut
    import da_pkg::*;
#(
    parameter int                     TAPS   = 4,
    parameter int                     COEF_W = 16,
    parameter logic [TAPS*COEF_W-1:0] COEFS  = '0,
    localparam int                    LUT_W  = lut_w(COEF_W, TAPS)
) (
    input  logic [TAPS-1:0]          addr,
    output logic signed [LUT_W-1:0]  entry
);

    function automatic logic signed [LUT_W-1:0] entry_of(input logic [TAPS-1:0] a);
        logic signed [LUT_W-1:0]  s;
        logic signed [COEF_W-1:0] c;
        logic [TAPS-1:0]          m;
        s = '0;
        for (int unsigned k = 0; k < TAPS; k++) begin
            m = a >> k;
            c = COEF_W'(COEFS >> (k * COEF_W));
            if (m[0]) s = s + LUT_W'(c);
        end
        return s;
    endfunction

    logic signed [LUT_W-1:0] rom [2**TAPS];

    for (genvar a = 0; a < 2**TAPS; a++) begin : g_rom
        assign rom[a] = entry_of(TAPS'(a));
    end

    assign entry = rom[addr];

endmodule

// File: rtl/da_dot_engine.sv
// Bit-serial distributed-arithmetic dot product y = sum x_k * c_k.
//   clk, rst_n  clock and asynchronous active-low reset
//   bus         da_dot_engine_if slave: sample vector in, result out, busy
// One sample bit per cycle, MSB first; the MSB step subtracts because it
// carries negative weight in two's complement. Result keeps full precision
// with the coefficients' fractional bits.
module da_dot_engine
    import da_pkg::*;
#(
    parameter int                     TAPS      = 4,
    parameter int                     IN_W      = 16,
    parameter int                     COEF_W    = 16,
    parameter int                     COEF_FRAC = 14,
    parameter logic [TAPS*COEF_W-1:0] COEFS     = '0
) (
    input logic           clk,
    input logic           rst_n,
    da_dot_engine_if.slave bus
);

    localparam int LUT_W = lut_w(COEF_W, TAPS);
    localparam int OUT_W = out_w(IN_W, COEF_W, TAPS);
    localparam int CNT_W = clog2(IN_W);

    if (TAPS < 2 || TAPS > 6 || IN_W < 2 || COEF_FRAC >= COEF_W) begin : g_bad_cfg
        $error("da_dot_engine: unsupported parameter set");
    end

    // Release is synchronised; assertion still takes effect immediately.
    logic [1:0] rst_sync;
    logic       rst_int_n;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) rst_sync <= '0;
        else        rst_sync <= {rst_sync[0], 1'b1};
    end

    assign rst_int_n = rst_sync[1];

    da_state_t state, state_nxt;
    logic      load, step, in_ready, out_valid, busy;

    logic [TAPS*IN_W-1:0]    samp;
    logic signed [OUT_W-1:0] acc;
    logic [CNT_W-1:0]        cnt;

    always_ff @(posedge clk or negedge rst_int_n) begin
        if (!rst_int_n) state <= ST_IDLE;
        else            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        load      = 1'b0;
        step      = 1'b0;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b0;
        case (state)
            ST_IDLE: begin
                in_ready = rst_int_n;
                if (bus.in_valid && rst_int_n) begin
                    load      = 1'b1;
                    state_nxt = ST_RUN;
                end
            end
            ST_RUN: begin
                busy = 1'b1;
                step = 1'b1;
                if (cnt == '0) state_nxt = ST_DONE;
            end
            ST_DONE: begin
                busy      = 1'b1;
                out_valid = 1'b1;
                if (bus.out_ready) state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // LUT address gathers bit cnt of every sample.
    logic [TAPS-1:0] lut_addr;

    for (genvar k = 0; k < TAPS; k++) begin : g_addr
        logic [IN_W-1:0] tap;
        assign tap         = samp[k*IN_W +: IN_W];
        assign lut_addr[k] = tap[cnt];
    end

    logic signed [LUT_W-1:0] lut_entry;

    da_lut #(
        .TAPS   (TAPS),
        .COEF_W (COEF_W),
        .COEFS  (COEFS)
    ) u_lut (
        .addr  (lut_addr),
        .entry (lut_entry)
    );

    logic signed [OUT_W-1:0] lut_ext, acc_dbl, acc_nxt;

    assign lut_ext = {{(OUT_W-LUT_W){lut_entry[LUT_W-1]}}, lut_entry};
    assign acc_dbl = {acc[OUT_W-2:0], 1'b0};
    assign acc_nxt = (cnt == CNT_W'(IN_W-1)) ? acc_dbl - lut_ext : acc_dbl + lut_ext;

    always_ff @(posedge clk or negedge rst_int_n) begin
        if (!rst_int_n) begin
            samp <= '0;
            acc  <= '0;
            cnt  <= '0;
        end else if (load) begin
            samp <= bus.in_data;
            acc  <= '0;
            cnt  <= CNT_W'(IN_W-1);
        end else if (step) begin
            acc <= acc_nxt;
            cnt <= cnt - CNT_W'(1);
        end
    end

    assign bus.in_ready  = in_ready;
    assign bus.out_valid = out_valid;
    assign bus.out_data  = acc;
    assign bus.busy      = busy;

endmodule

// File: tb/tb_da_dot_engine.sv
// Scoreboard bench for da_dot_engine: two instances (unit and DCT
// coefficients) share stimulus, selected by sel.
module tb_da_dot_engine;

    localparam int TAPS   = 4;
    localparam int IN_W   = 8;
    localparam int COEF_W = 16;
    localparam int OUT_W  = 26;

    localparam logic [63:0] UNIT_COEFS = {4{16'h4000}};
    localparam logic [63:0] DCT_COEFS  = {16'h0C7C, 16'hDC72, 16'h3537, 16'hC13B};

    typedef struct {
        logic signed [OUT_W-1:0] data;
        int                      acc_cyc;
    } exp_t;

    exp_t sb[$];

    logic        clk       = 1'b0;
    logic        rst_n     = 1'b1;
    logic        sel       = 1'b0;
    logic        in_valid  = 1'b0;
    logic        out_ready = 1'b1;
    logic [31:0] in_data   = '0;

    logic                    in_ready_m, out_valid_m, busy_m;
    logic signed [OUT_W-1:0] out_data_m;

    int cyc = 0;
    int checks = 0;
    int errors = 0;
    int accepted = 0;
    int discarded = 0;
    int results = 0;
    int last_acc = 0;
    int prev_acc = 0;
    logic                    seen = 1'b0;
    logic signed [OUT_W-1:0] held = '0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    da_dot_engine_if #(.TAPS(TAPS), .IN_W(IN_W), .COEF_W(COEF_W)) if_u ();
    da_dot_engine_if #(.TAPS(TAPS), .IN_W(IN_W), .COEF_W(COEF_W)) if_d ();

    assign if_u.in_valid  = in_valid & ~sel;
    assign if_d.in_valid  = in_valid & sel;
    assign if_u.in_data   = in_data;
    assign if_d.in_data   = in_data;
    assign if_u.out_ready = out_ready;
    assign if_d.out_ready = out_ready;

    assign in_ready_m  = sel ? if_d.in_ready  : if_u.in_ready;
    assign out_valid_m = sel ? if_d.out_valid : if_u.out_valid;
    assign out_data_m  = sel ? if_d.out_data  : if_u.out_data;
    assign busy_m      = sel ? if_d.busy      : if_u.busy;

    da_dot_engine #(
        .TAPS(TAPS), .IN_W(IN_W), .COEF_W(COEF_W), .COEF_FRAC(14), .COEFS(UNIT_COEFS)
    ) dut_unit (
        .clk(clk), .rst_n(rst_n), .bus(if_u)
    );

    da_dot_engine #(
        .TAPS(TAPS), .IN_W(IN_W), .COEF_W(COEF_W), .COEF_FRAC(14), .COEFS(DCT_COEFS)
    ) dut_dct (
        .clk(clk), .rst_n(rst_n), .bus(if_d)
    );

    function automatic logic [31:0] pack4(input int x0, input int x1, input int x2, input int x3);
        return {8'(x3), 8'(x2), 8'(x1), 8'(x0)};
    endfunction

    function automatic longint model(input logic [31:0] d, input logic [63:0] co);
        longint            s;
        logic signed [7:0]  xs;
        logic signed [15:0] cs;
        s = 0;
        for (int k = 0; k < TAPS; k++) begin
            xs = 8'(d >> (8 * k));
            cs = 16'(co >> (16 * k));
            s += longint'(xs) * longint'(cs);
        end
        return s;
    endfunction

    task automatic check(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic send(input logic [31:0] d, input longint expv);
        exp_t e;
        int   n;
        n        = 0;
        in_data  = d;
        in_valid = 1'b1;
        do begin
            @(negedge clk);
            n++;
        end while (!in_ready_m && n < 200);
        if (!in_ready_m) begin
            checks++;
            errors++;
            $display("FAIL accept_timeout: in_ready low for %0d cycles, expected 1", n);
        end else begin
            e.data    = OUT_W'(expv);
            e.acc_cyc = cyc + 1;
            last_acc  = e.acc_cyc;
            sb.push_back(e);
            accepted++;
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        check("run_busy", busy_m, 1);
        check("run_in_ready", in_ready_m, 0);
    endtask

    task automatic wait_drain();
        int n;
        n = 0;
        while (sb.size() != 0 && n < 200) begin
            @(posedge clk);
            n++;
        end
        if (sb.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL drain_timeout: %0d results pending, expected 0", sb.size());
        end
        #1;
    endtask

    task automatic wait_out_valid();
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!out_valid_m && n < 200);
        if (!out_valid_m) begin
            checks++;
            errors++;
            $display("FAIL out_valid_timeout: out_valid low for %0d cycles, expected 1", n);
        end
    endtask

    task automatic monitor();
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                seen = 1'b0;
            end else if (out_valid_m) begin
                if (sb.size() == 0) begin
                    if (out_ready) begin
                        checks++;
                        errors++;
                        $display("FAIL spurious_result: got out_data %0d, expected no result", out_data_m);
                    end
                end else begin
                    if (!seen) begin
                        check("latency", cyc - sb[0].acc_cyc, IN_W);
                        seen = 1'b1;
                        held = out_data_m;
                    end else begin
                        check("stall_hold", out_data_m, held);
                    end
                    check("done_busy", busy_m, 1);
                    check("done_in_ready", in_ready_m, 0);
                    if (out_ready) begin
                        check("result", out_data_m, sb[0].data);
                        void'(sb.pop_front());
                        seen = 1'b0;
                        results++;
                    end
                end
            end
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [31:0] d;
        fork
            monitor();
        join_none

        #2 rst_n = 1'b0;
        #1;
        check("rst_in_ready", in_ready_m, 0);
        check("rst_out_valid", out_valid_m, 0);
        check("rst_busy", busy_m, 0);
        check("rst_out_data", out_data_m, 0);
        repeat (2) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1 check("sync_edge1_in_ready", in_ready_m, 0);
        @(posedge clk); #1 check("sync_edge2_in_ready", in_ready_m, 1);

        // unit coefficients (1.0 in Q2.14)
        send(pack4(1, 2, 3, 4), 163840);
        send(pack4(-128, 0, 0, 0), -2097152);
        send(pack4(127, 127, 127, 127), 8323072);
        send(pack4(-128, -128, -128, -128), -8388608);
        send(pack4(-1, 5, 0, -7), -49152);
        wait_drain();

        // result stalled in DONE with stray in_valid pulses
        out_ready = 1'b0;
        send(pack4(1, 2, 3, 4), 163840);
        wait_out_valid();
        for (int i = 0; i < 5; i++) begin
            in_data  = pack4(9, 9, 9, 9);
            in_valid = (i == 2);
            @(negedge clk);
            check("stall_in_ready", in_ready_m, 0);
            @(posedge clk);
            #1;
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        send(pack4(-1, 5, 0, -7), -49152);
        wait_drain();

        // reset while RUN is on bit 3
        send(pack4(1, 1, 1, 1), 65536);
        repeat (4) @(posedge clk);
        #2 rst_n = 1'b0;
        void'(sb.pop_back());
        discarded++;
        #1;
        check("midrun_rst_out_valid", out_valid_m, 0);
        check("midrun_rst_out_data", out_data_m, 0);
        check("midrun_rst_busy", busy_m, 0);
        check("midrun_rst_in_ready", in_ready_m, 0);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1 check("midrun_sync_in_ready", in_ready_m, 0);
        send(pack4(3, -2, 0, 1), 32768);
        wait_drain();

        // DCT coefficients {c7, -c5, c3, -c1}
        sel = 1'b1;
        send(pack4(1, 0, 0, 0), -16069);
        send(pack4(1, 1, 1, 1), -8352);
        send(pack4(-128, 0, 0, 0), 2056832);
        send(pack4(10, -20, 30, -40), -834050);
        send(pack4(0, 0, 0, 127), 405892);
        wait_drain();

        for (int i = 0; i < 1000; i++) begin
            d = $urandom();
            send(d, model(d, DCT_COEFS));
            if (i > 0) check("b2b_period", last_acc - prev_acc, IN_W + 2);
            prev_acc = last_acc;
        end
        wait_drain();
        repeat (12) @(posedge clk);
        #1;

        check("result_count", results, accepted - discarded);
        check("sb_empty", sb.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
